// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared types, constants and helpers for the parametrised FIR filter
// Purpose: FSM state encoding, sample-period budget and the output clamp used
//          when saturation is built in.
// Ports:   none (package)
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } fir_state_t;

    // 12 MHz / 600 kHz: clocks available between sample strobes.  A full
    // sequence (strobe edge, NTAP MAC edges, DONE edge) must fit inside it.
    localparam int CLKS_PER_SAMPLE = 20;

    // Clamp a sign-extended value into the signed range of an outW-bit word.
    // The caller sign-extends into 64 bits and slices the low outW bits back out.
    function automatic logic signed [63:0] sat_clamp(
        input logic signed [63:0] val,
        input int                 outW
    );
        logic signed [63:0] hiLim;
        logic signed [63:0] loLim;
        hiLim = (64'sd1 <<< (outW - 1)) - 64'sd1;
        loLim = -hiLim - 64'sd1;
        if (val > hiLim) begin
            return hiLim;
        end else if (val < loLim) begin
            return loLim;
        end
        return val;
    endfunction

endpackage

// File: rtl/fir_filter_param_if.sv
// rtl/fir_filter_param_if.sv - sample, coefficient and result bundle of the FIR filter
// Purpose: groups the strobe/sample input, the coefficient write port and the
//          filter result/status outputs.
// Signals: iEnSample_600kHz, iFirIn          sample strobe and signed sample
//          iCoefWe, iCoefAddr, iCoefData      coefficient write port
//          oFirOut, oValid, oBusy, oOverrun   result and status
// Modports: master drives samples/coefficients, slave is the filter.
interface fir_filter_param_if #(
    parameter int IN_W   = 3,
    parameter int COEF_W = 8,
    parameter int NTAP   = 16,
    parameter int OUT_W  = 16
) ();

    logic                        iEnSample_600kHz;
    logic signed [IN_W-1:0]      iFirIn;
    logic                        iCoefWe;
    logic [$clog2(NTAP)-1:0]     iCoefAddr;
    logic signed [COEF_W-1:0]    iCoefData;
    logic signed [OUT_W-1:0]     oFirOut;
    logic                        oValid;
    logic                        oBusy;
    logic                        oOverrun;

    modport master (
        output iEnSample_600kHz,
        output iFirIn,
        output iCoefWe,
        output iCoefAddr,
        output iCoefData,
        input  oFirOut,
        input  oValid,
        input  oBusy,
        input  oOverrun
    );

    modport slave (
        input  iEnSample_600kHz,
        input  iFirIn,
        input  iCoefWe,
        input  iCoefAddr,
        input  iCoefData,
        output oFirOut,
        output oValid,
        output oBusy,
        output oOverrun
    );

endinterface

// File: rtl/fir_mac.sv
// rtl/fir_mac.sv - registered signed multiply-accumulate datapath, one tap per clock
// Purpose: acc <= 0 on iClear, acc <= acc + tap*coef on iEn (full ACC_W signed).
// Ports:   iClk_12MHz  clock
//          iRst        asynchronous active-high reset, clears acc
//          iClear      synchronous clear (takes priority over iEn)
//          iEn         accumulate this clock
//          iTap        signed sample operand (IN_W)
//          iCoef       signed coefficient operand (COEF_W)
//          oAcc        signed accumulator (ACC_W)
module fir_mac #(
    parameter int IN_W   = 3,
    parameter int COEF_W = 8,
    parameter int ACC_W  = 15
) (
    input  logic                     iClk_12MHz,
    input  logic                     iRst,
    input  logic                     iClear,
    input  logic                     iEn,
    input  logic signed [IN_W-1:0]   iTap,
    input  logic signed [COEF_W-1:0] iCoef,
    output logic signed [ACC_W-1:0]  oAcc
);

    logic signed [ACC_W-1:0] tapExt;
    logic signed [ACC_W-1:0] coefExt;
    logic signed [ACC_W-1:0] product;

    // Sign-extend both operands to the accumulator width first so the product
    // is computed signed at full precision; ACC_W always covers IN_W+COEF_W.
    always_comb begin
        tapExt  = ACC_W'(iTap);
        coefExt = ACC_W'(iCoef);
        product = tapExt * coefExt;
    end

    always_ff @(posedge iClk_12MHz or posedge iRst) begin
        if (iRst) begin
            oAcc <= '0;
        end else if (iClear) begin
            oAcc <= '0;
        end else if (iEn) begin
            oAcc <= oAcc + product;
        end
    end

endmodule

// File: rtl/fir_filter_param.sv
// rtl/fir_filter_param.sv - time-multiplexed parametrised FIR filter, one tap per clock
// Purpose: on each sample strobe shifts the delay line and runs NTAP MAC clocks
//          through a single multiplier, then publishes the scaled and sized
//          accumulator.  Coefficients are runtime-loadable while idle.
// Build option: define FIR_SAT_EN to clamp the output instead of wrapping.
// Ports:   iClk_12MHz  12 MHz system clock
//          iRst        asynchronous active-high reset
//          firBus      fir_filter_param_if.slave: strobe/sample in, coefficient
//                      write port, oFirOut/oValid/oBusy/oOverrun out
module fir_filter_param
    import fir_pkg::*;
#(
    parameter int IN_W   = 3,
    parameter int COEF_W = 8,
    parameter int NTAP   = 16,
    parameter int OUT_W  = 16,
    parameter int SHIFT  = 0
) (
    input  logic             iClk_12MHz,
    input  logic             iRst,
    fir_filter_param_if.slave firBus
);

    localparam int ACC_W = IN_W + COEF_W + $clog2(NTAP);
    localparam int KW    = $clog2(NTAP);

    fir_state_t               state;
    logic [KW-1:0]            k;
    logic signed [IN_W-1:0]   taps  [NTAP];
    logic signed [COEF_W-1:0] coefs [NTAP];
    logic signed [ACC_W-1:0]  acc;
    logic signed [OUT_W-1:0]  firOut;
    logic                     valid;
    logic                     busy;
    logic                     overrun;

    logic                     macClear;
    logic                     macEn;
    logic                     coefWrite;
    logic signed [ACC_W-1:0]  accShift;
    logic signed [63:0]       accWide;
    logic signed [63:0]       accClamped;
    logic signed [OUT_W-1:0]  sizedOut;

    // Accumulator clear coincides with the strobe edge so the first MAC clock
    // starts from zero; tap k is consumed on the edge that advances k.
    assign macClear  = (state == IDLE) && firBus.iEnSample_600kHz;
    assign macEn     = (state == MAC);
    assign coefWrite = (state == IDLE) && firBus.iCoefWe
                       && (int'(firBus.iCoefAddr) < NTAP);

    fir_mac #(
        .IN_W   (IN_W),
        .COEF_W (COEF_W),
        .ACC_W  (ACC_W)
    ) uMac (
        .iClk_12MHz (iClk_12MHz),
        .iRst       (iRst),
        .iClear     (macClear),
        .iEn        (macEn),
        .iTap       (taps[k]),
        .iCoef      (coefs[k]),
        .oAcc       (acc)
    );

    // Scale then size.  Going through a 64-bit sign-extended copy makes the
    // OUT_W >= ACC_W case a plain sign extension and OUT_W < ACC_W a wrap.
    always_comb begin
        accShift   = acc >>> SHIFT;
        accWide    = 64'(accShift);
        accClamped = sat_clamp(accWide, OUT_W);
`ifdef FIR_SAT_EN
        sizedOut   = OUT_W'(accClamped);
`else
        sizedOut   = OUT_W'(accWide);
`endif
    end

    always_ff @(posedge iClk_12MHz or posedge iRst) begin
        if (iRst) begin
            state   <= IDLE;
            k       <= '0;
            firOut  <= '0;
            valid   <= 1'b0;
            busy    <= 1'b0;
            overrun <= 1'b0;
            for (int i = 0; i < NTAP; i++) begin
                taps[i]  <= '0;
                coefs[i] <= '0;
            end
        end else begin
            valid   <= 1'b0;
            overrun <= 1'b0;
            case (state)
                IDLE: begin
                    // A write on the strobe edge lands before MAC reads it.
                    if (coefWrite) begin
                        coefs[firBus.iCoefAddr] <= firBus.iCoefData;
                    end
                    if (firBus.iEnSample_600kHz) begin
                        taps[0] <= firBus.iFirIn;
                        for (int i = 1; i < NTAP; i++) begin
                            taps[i] <= taps[i-1];
                        end
                        k     <= '0;
                        busy  <= 1'b1;
                        state <= MAC;
                    end
                end
                MAC: begin
                    // Samples arriving mid-sequence are dropped, not queued.
                    if (firBus.iEnSample_600kHz) begin
                        overrun <= 1'b1;
                    end
                    if (k == KW'(NTAP - 1)) begin
                        state <= DONE;
                    end
                    k <= k + 1'b1;
                end
                DONE: begin
                    if (firBus.iEnSample_600kHz) begin
                        overrun <= 1'b1;
                    end
                    firOut <= sizedOut;
                    valid  <= 1'b1;
                    busy   <= 1'b0;
                    k      <= '0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign firBus.oFirOut  = firOut;
    assign firBus.oValid   = valid;
    assign firBus.oBusy    = busy;
    assign firBus.oOverrun = overrun;

endmodule

// File: tb/tb_fir_filter_param.sv
// tb/tb_fir_filter_param.sv - directed self-checking bench for fir_filter_param
module tb_fir_filter_param;

    logic clk;
    logic rst;
    int   nCompared;
    int   nMismatched;

    fir_filter_param_if #(.IN_W(3), .COEF_W(8), .NTAP(16), .OUT_W(16)) bus ();
    fir_filter_param_if #(.IN_W(3), .COEF_W(8), .NTAP(16), .OUT_W(8))  bus8 ();

    fir_filter_param #(.IN_W(3), .COEF_W(8), .NTAP(16), .OUT_W(16), .SHIFT(0)) dut (
        .iClk_12MHz (clk),
        .iRst       (rst),
        .firBus     (bus)
    );

    fir_filter_param #(.IN_W(3), .COEF_W(8), .NTAP(16), .OUT_W(8), .SHIFT(0)) dut8 (
        .iClk_12MHz (clk),
        .iRst       (rst),
        .firBus     (bus8)
    );

    assign bus8.iEnSample_600kHz = bus.iEnSample_600kHz;
    assign bus8.iFirIn           = bus.iFirIn;
    assign bus8.iCoefWe          = bus.iCoefWe;
    assign bus8.iCoefAddr        = bus.iCoefAddr;
    assign bus8.iCoefData        = bus.iCoefData;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // mode 0: coef[k] = k+1, mode 1: coef[k] = 127
    task automatic load_coefs(input int mode);
        for (int i = 0; i < 16; i++) begin
            bus.iCoefWe   = 1'b1;
            bus.iCoefAddr = 4'(i);
            bus.iCoefData = (mode == 0) ? 8'(i + 1) : 8'sd127;
            tick();
        end
        bus.iCoefWe = 1'b0;
    endtask

    // Strobe one sample, wait for oValid (bounded), then pad to 20 clocks.
    task automatic strobe_wait(input logic signed [2:0] s, output int lat);
        bus.iEnSample_600kHz = 1'b1;
        bus.iFirIn           = s;
        tick();
        bus.iEnSample_600kHz = 1'b0;
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (bus.oValid) begin
                lat = c;
                break;
            end
        end
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        nCompared++;
        if (bus.oFirOut !== 16'd0) begin
            nMismatched++;
            $display("FAIL reset_out: got %h want 0000", bus.oFirOut);
        end
        nCompared++;
        if ({bus.oValid, bus.oBusy, bus.oOverrun} !== 3'b000) begin
            nMismatched++;
            $display("FAIL reset_flags: got %b want 000", {bus.oValid, bus.oBusy, bus.oOverrun});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_impulse_pos();
        int lat;
        logic signed [15:0] expOut;
        do_reset();
        load_coefs(0);
        for (int i = 0; i < 17; i++) begin
            strobe_wait((i == 0) ? 3'sd1 : 3'sd0, lat);
            expOut = (i < 16) ? 16'(i + 1) : 16'd0;
            nCompared++;
            if (lat !== 17) begin
                nMismatched++;
                $display("FAIL impulse_pos_latency[%0d]: got %0d want 17", i, lat);
            end
            nCompared++;
            if (bus.oFirOut !== expOut) begin
                nMismatched++;
                $display("FAIL impulse_pos_out[%0d]: got %0d want %0d", i, bus.oFirOut, expOut);
            end
        end
    endtask

    task automatic test_impulse_neg();
        int lat;
        logic signed [15:0] expOut;
        for (int i = 0; i < 16; i++) begin
            strobe_wait((i == 0) ? -3'sd1 : 3'sd0, lat);
            expOut = 16'(-(i + 1));
            nCompared++;
            if (bus.oFirOut !== expOut || lat !== 17) begin
                nMismatched++;
                $display("FAIL impulse_neg_out[%0d]: got %h lat %0d want %h lat 17",
                         i, bus.oFirOut, lat, expOut);
            end
        end
    endtask

    task automatic test_step();
        int lat;
        logic [7:0] exp8;
`ifdef FIR_SAT_EN
        exp8 = 8'h7F;
`else
        exp8 = 8'hD0;
`endif
        load_coefs(1);
        for (int i = 0; i < 16; i++) begin
            strobe_wait(3'sd3, lat);
            if (i == 0) begin
                nCompared++;
                if (bus.oFirOut !== 16'sd381) begin
                    nMismatched++;
                    $display("FAIL step_first: got %0d want 381", bus.oFirOut);
                end
            end
        end
        nCompared++;
        if (bus.oFirOut !== 16'sd6096) begin
            nMismatched++;
            $display("FAIL step_final: got %0d want 6096", bus.oFirOut);
        end
        nCompared++;
        if (bus8.oFirOut !== exp8) begin
            nMismatched++;
            $display("FAIL step_out8: got %h want %h", bus8.oFirOut, exp8);
        end
    endtask

    task automatic test_overrun();
        int nOv;
        int nVal;
        int valAt;
        int lat;
        logic busyMid;
        do_reset();
        load_coefs(0);
        nOv = 0;
        nVal = 0;
        valAt = 0;
        busyMid = 1'b0;
        bus.iEnSample_600kHz = 1'b1;
        bus.iFirIn           = 3'sd1;
        tick();
        bus.iEnSample_600kHz = 1'b0;
        for (int c = 1; c <= 25; c++) begin
            if (c == 5) begin
                bus.iEnSample_600kHz = 1'b1;
                bus.iFirIn           = 3'sd2;
            end
            tick();
            bus.iEnSample_600kHz = 1'b0;
            if (c == 2) busyMid = bus.oBusy;
            if (bus.oOverrun) nOv++;
            if (bus.oValid) begin
                nVal++;
                valAt = c;
            end
        end
        nCompared++;
        if (busyMid !== 1'b1) begin
            nMismatched++;
            $display("FAIL busy_in_mac: got %b want 1", busyMid);
        end
        nCompared++;
        if (nOv !== 1) begin
            nMismatched++;
            $display("FAIL overrun_count: got %0d want 1", nOv);
        end
        nCompared++;
        if (nVal !== 1 || valAt !== 17) begin
            nMismatched++;
            $display("FAIL overrun_valid: got %0d at %0d want 1 at 17", nVal, valAt);
        end
        nCompared++;
        if (bus.oFirOut !== 16'sd1 || bus.oBusy !== 1'b0) begin
            nMismatched++;
            $display("FAIL overrun_out: got %0d busy %b want 1 busy 0", bus.oFirOut, bus.oBusy);
        end
        strobe_wait(3'sd0, lat);
        nCompared++;
        if (bus.oFirOut !== 16'sd2) begin
            nMismatched++;
            $display("FAIL overrun_delay_line: got %0d want 2", bus.oFirOut);
        end
    endtask

    task automatic test_coef_busy();
        int lat;
        logic signed [15:0] got;
        do_reset();
        load_coefs(0);
        got = '0;
        bus.iEnSample_600kHz = 1'b1;
        bus.iFirIn           = 3'sd1;
        tick();
        bus.iEnSample_600kHz = 1'b0;
        for (int c = 1; c <= 25; c++) begin
            if (c == 3) begin
                bus.iCoefWe   = 1'b1;
                bus.iCoefAddr = 4'd0;
                bus.iCoefData = 8'sd50;
            end
            tick();
            bus.iCoefWe = 1'b0;
            if (bus.oValid) got = bus.oFirOut;
        end
        nCompared++;
        if (got !== 16'sd1) begin
            nMismatched++;
            $display("FAIL coef_busy_current: got %0d want 1", got);
        end
        strobe_wait(3'sd1, lat);
        nCompared++;
        if (bus.oFirOut !== 16'sd3) begin
            nMismatched++;
            $display("FAIL coef_busy_next: got %0d want 3", bus.oFirOut);
        end
        // write coef[2] = 10 on the same edge as a strobe of 0
        bus.iEnSample_600kHz = 1'b1;
        bus.iFirIn           = 3'sd0;
        bus.iCoefWe          = 1'b1;
        bus.iCoefAddr        = 4'd2;
        bus.iCoefData        = 8'sd10;
        tick();
        bus.iEnSample_600kHz = 1'b0;
        bus.iCoefWe          = 1'b0;
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (bus.oValid) begin
                lat = c;
                break;
            end
        end
        nCompared++;
        if (bus.oFirOut !== 16'sd12 || lat !== 17) begin
            nMismatched++;
            $display("FAIL coef_write_with_strobe: got %0d lat %0d want 12 lat 17", bus.oFirOut, lat);
        end
        tick();
        tick();
    endtask

    task automatic test_reset_mid_mac();
        int nVal;
        nVal = 0;
        bus.iEnSample_600kHz = 1'b1;
        bus.iFirIn           = 3'sd1;
        tick();
        bus.iEnSample_600kHz = 1'b0;
        repeat (8) tick();
        nCompared++;
        if (bus.oBusy !== 1'b1 || bus.oFirOut !== 16'sd12) begin
            nMismatched++;
            $display("FAIL pre_reset_state: got busy %b out %0d want busy 1 out 12", bus.oBusy, bus.oFirOut);
        end
        rst = 1'b1;
        #1;
        nCompared++;
        if ({bus.oBusy, bus.oValid} !== 2'b00 || bus.oFirOut !== 16'd0) begin
            nMismatched++;
            $display("FAIL reset_mid_mac: got busy %b valid %b out %0d want 0 0 0",
                     bus.oBusy, bus.oValid, bus.oFirOut);
        end
        tick();
        rst = 1'b0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (bus.oValid) nVal++;
        end
        nCompared++;
        if (nVal !== 0) begin
            nMismatched++;
            $display("FAIL no_valid_after_reset: got %0d want 0", nVal);
        end
    endtask

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        rst                  = 1'b1;
        bus.iEnSample_600kHz = 1'b0;
        bus.iFirIn           = '0;
        bus.iCoefWe          = 1'b0;
        bus.iCoefAddr        = '0;
        bus.iCoefData        = '0;
        test_reset();
        test_impulse_pos();
        test_impulse_neg();
        test_step();
        test_overrun();
        test_coef_busy();
        test_reset_mid_mac();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
